// File: rtl/nist_freq_pkg.sv
// Shared constants and width helpers for the NIST frequency-test engine.
package nist_freq_pkg;

  // FSM encoding
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_EVAL    = 2'd1;
  localparam logic [1:0] ST_HOLD    = 2'd2;

  // Default pass limits for n=128, M=16 at p >= 0.01
  localparam int DEF_MONO_LIMIT = 29;   // floor(2.5758*sqrt(128))
  localparam int DEF_BF_LIMIT   = 321;  // floor(20.09*16)

  // Signed width holding +/-seq_len
  function automatic int sum_w(input int seq_len);
    return $clog2(seq_len + 1) + 1;
  endfunction

  // Width of the sum of squared block deviations; max value is seq_len*blk_len
  function automatic int sq_w(input int seq_len, input int blk_len);
    return $clog2(seq_len * blk_len + 1);
  endfunction

endpackage

// File: rtl/nist_blk_acc.sv
// Block-frequency accumulator: per-block +/-1 deviation, squared and summed
// into sq_acc at each block boundary.
module nist_blk_acc
  import nist_freq_pkg::*;
#(
  parameter int SEQ_LEN = 128,
  parameter int BLK_LEN = 16,
  localparam int SQW = sq_w(SEQ_LEN, BLK_LEN)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           bit_val,
  input  logic           strobe,
  input  logic           clear,
  output logic [SQW-1:0] sq_acc
);

  localparam int DW  = $clog2(BLK_LEN + 1) + 1;  // signed block deviation
  localparam int MW  = DW - 1;                   // |d| <= BLK_LEN
  localparam int BCW = $clog2(BLK_LEN);

  logic [DW-1:0]   blk_acc, d, d_neg;
  logic [MW-1:0]   d_mag;
  logic [2*MW-1:0] d_sq;
  logic [BCW-1:0]  blk_cnt;
  logic            blk_end;

  // Deviation including the bit being accepted, its magnitude and square
  always_comb begin
    d       = blk_acc + (bit_val ? DW'(1) : {DW{1'b1}});
    d_neg   = -d;
    d_mag   = d[DW-1] ? d_neg[MW-1:0] : d[MW-1:0];
    d_sq    = {{MW{1'b0}}, d_mag} * {{MW{1'b0}}, d_mag};
    blk_end = (blk_cnt == BCW'(BLK_LEN - 1));
  end

  // Block counter, running deviation and square accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_acc <= '0;
      blk_cnt <= '0;
      sq_acc  <= '0;
    end else if (clear) begin
      blk_acc <= '0;
      blk_cnt <= '0;
      sq_acc  <= '0;
    end else if (strobe) begin
      if (blk_end) begin
        blk_acc <= '0;
        blk_cnt <= '0;
        sq_acc  <= sq_acc + SQW'(d_sq);
      end else begin
        blk_acc <= d;
        blk_cnt <= blk_cnt + BCW'(1);
      end
    end
  end

endmodule

// File: rtl/nist_freq_tester.sv
// NIST SP 800-22 monobit + block-frequency tester over fixed-length serial
// sequences. Bits are collected one per cycle, judged in a single EVAL cycle,
// and the verdict is held until the consumer takes it. Chip pin mapping
// (ui_in/uo_out) lives in the chip-level wrapper.
module nist_freq_tester
  import nist_freq_pkg::*;
#(
  parameter int SEQ_LEN    = 128,
  parameter int BLK_LEN    = 16,
  parameter int MONO_LIMIT = DEF_MONO_LIMIT,
  parameter int BF_LIMIT   = DEF_BF_LIMIT,
  localparam int SW = sum_w(SEQ_LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          bit_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          mono_pass,
  output logic          bf_pass,
  output logic [SW-1:0] s_sum,
  output logic [7:0]    fail_cnt
);

  localparam int SQW    = sq_w(SEQ_LEN, BLK_LEN);
  localparam int CW     = $clog2(SEQ_LEN);
  // Limits beyond the reachable range always pass; clamp so they fit the compare width
  localparam int MONO_C = (MONO_LIMIT > SEQ_LEN) ? SEQ_LEN : MONO_LIMIT;
  localparam int BF_C   = (BF_LIMIT > SEQ_LEN * BLK_LEN) ? SEQ_LEN * BLK_LEN : BF_LIMIT;
  localparam logic [SW-1:0]  MONO_LIM = SW'(MONO_C);
  localparam logic [SQW-1:0] BF_LIM   = SQW'(BF_C);

  logic [1:0]     state;
  logic [SW-1:0]  s_acc, s_abs;
  logic [CW-1:0]  bit_cnt;
  logic [SQW-1:0] sq_acc;
  logic           accept, last_bit, take, mono_ok, bf_ok;

  // Handshake decode and verdict compares
  always_comb begin
    in_ready = (state == ST_COLLECT);
    accept   = in_valid & in_ready;
    last_bit = (bit_cnt == CW'(SEQ_LEN - 1));
    take     = res_valid & res_ready;
    s_abs    = s_acc[SW-1] ? -s_acc : s_acc;  // -SEQ_LEN negates cleanly in SW bits
    mono_ok  = (s_abs <= MONO_LIM);
    bf_ok    = (sq_acc <= BF_LIM);
  end

  nist_blk_acc #(
    .SEQ_LEN (SEQ_LEN),
    .BLK_LEN (BLK_LEN)
  ) u_blk (
    .clk     (clk),
    .rst_n   (rst_n),
    .bit_val (bit_in),
    .strobe  (accept),
    .clear   (clear | take),
    .sq_acc  (sq_acc)
  );

  // Sequence FSM, running sum and registered result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_COLLECT;
      s_acc     <= '0;
      bit_cnt   <= '0;
      res_valid <= 1'b0;
      mono_pass <= 1'b0;
      bf_pass   <= 1'b0;
      s_sum     <= '0;
      fail_cnt  <= '0;
    end else if (clear) begin
      // Verdicts and the failure tally survive an abort
      state     <= ST_COLLECT;
      s_acc     <= '0;
      bit_cnt   <= '0;
      res_valid <= 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            s_acc   <= s_acc + (bit_in ? SW'(1) : {SW{1'b1}});
            bit_cnt <= bit_cnt + CW'(1);
            if (last_bit) state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          mono_pass <= mono_ok;
          bf_pass   <= bf_ok;
          s_sum     <= s_acc;
          if ((!mono_ok || !bf_ok) && fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            state     <= ST_COLLECT;
            res_valid <= 1'b0;
            s_acc     <= '0;
            bit_cnt   <= '0;
          end
        end
        default: state <= ST_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_nist_freq_tester.sv
// Scoreboard bench for nist_freq_tester at default parameters (n=128, M=16).
module tb_nist_freq_tester;

  localparam int SW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          bit_in = 1'b0;
  logic          in_valid = 1'b0;
  logic          res_ready = 1'b0;
  logic          in_ready, res_valid, mono_pass, bf_pass;
  logic [SW-1:0] s_sum;
  logic [7:0]    fail_cnt;

  int checks = 0;
  int errors = 0;
  int exp_fail = 0;

  typedef struct {
    int s;
    int sq;
    bit mono;
    bit bf;
    int fcnt;
  } exp_t;

  exp_t sb[$];

  nist_freq_tester dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .bit_in    (bit_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .mono_pass (mono_pass),
    .bf_pass   (bf_pass),
    .s_sum     (s_sum),
    .fail_cnt  (fail_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- patterns ----------------
  function automatic logic [127:0] pat_alt();
    logic [127:0] p;
    for (int i = 0; i < 128; i++) p[i] = (i % 2 == 1);
    return p;
  endfunction

  function automatic logic [127:0] pat_half();
    logic [127:0] p;
    for (int i = 0; i < 128; i++) p[i] = (i < 64);
    return p;
  endfunction

  // n ones spread evenly across the sequence
  function automatic logic [127:0] pat_spread(input int n);
    logic [127:0] p;
    for (int i = 0; i < 128; i++) p[i] = (((i + 1) * n) / 128) != ((i * n) / 128);
    return p;
  endfunction

  // ---------------- reference model ----------------
  task automatic push_exp(input logic [127:0] bits);
    exp_t e;
    int d, a;
    e.s = 0;
    e.sq = 0;
    for (int b = 0; b < 8; b++) begin
      d = 0;
      for (int j = 0; j < 16; j++) d += bits[b*16+j] ? 1 : -1;
      e.sq += d * d;
      e.s  += d;
    end
    a = (e.s < 0) ? -e.s : e.s;
    e.mono = (a <= 29);
    e.bf   = (e.sq <= 321);
    if ((!e.mono || !e.bf) && exp_fail < 255) exp_fail++;
    e.fcnt = exp_fail;
    sb.push_back(e);
  endtask

  // ---------------- drivers ----------------
  task automatic send_bits(input logic [127:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      k = 0;
      @(negedge clk);
      while (!in_ready && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("FAIL send_wait: in_ready=%b required 1 (bit %0d)", in_ready, i);
      end
      bit_in   = bits[i];
      in_valid = 1'b1;
    end
  endtask

  task automatic send_seq(input logic [127:0] bits);
    push_exp(bits);
    send_bits(bits, 128);
    @(negedge clk);
    in_valid = 1'b0;
    bit_in   = 1'b0;
  endtask

  task automatic wait_res(input string name);
    int k;
    k = 0;
    while (!res_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!res_valid) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: res_valid=0 required 1", name);
    end
  endtask

  // Wait for a result, compare it against the scoreboard head, then take it
  task automatic take_result(input string name);
    exp_t e;
    wait_res(name);
    if (!res_valid) return;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: unexpected result, scoreboard empty", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (int'($signed(s_sum)) !== e.s) begin
      errors++; $display("FAIL %s_s_sum: got %0d required %0d", name, $signed(s_sum), e.s);
    end
    checks++;
    if (mono_pass !== e.mono) begin
      errors++; $display("FAIL %s_mono: got %b required %b", name, mono_pass, e.mono);
    end
    checks++;
    if (bf_pass !== e.bf) begin
      errors++; $display("FAIL %s_bf: got %b required %b", name, bf_pass, e.bf);
    end
    checks++;
    if (int'(fail_cnt) !== e.fcnt) begin
      errors++; $display("FAIL %s_fail_cnt: got %0d required %0d", name, fail_cnt, e.fcnt);
    end
    checks++;
    if (int'(dut.u_blk.sq_acc) !== e.sq) begin
      errors++; $display("FAIL %s_sq_acc: got %0d required %0d", name, dut.u_blk.sq_acc, e.sq);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_take: res_valid=%b in_ready=%b required 0/1", name, res_valid, in_ready);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (res_valid !== 1'b0 || mono_pass !== 1'b0 || bf_pass !== 1'b0 ||
        s_sum !== '0 || fail_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs: rv=%b mp=%b bp=%b s=%0d fc=%0d required all 0",
               res_valid, mono_pass, bf_pass, s_sum, fail_cnt);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_all_ones();
    send_seq('1);
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL ones_eval: res_valid=%b in_ready=%b required 0/0", res_valid, in_ready);
    end
    @(negedge clk);
    checks++;
    if (res_valid !== 1'b1) begin
      errors++; $display("FAIL ones_latency: res_valid=%b required 1", res_valid);
    end
    take_result("ones");
  endtask

  task automatic test_alternating();
    send_seq(pat_alt());
    take_result("alt");
  endtask

  task automatic test_diverge();
    send_seq(pat_half());
    take_result("half");
  endtask

  task automatic test_mono_boundary();
    send_seq(pat_spread(78));
    take_result("mono78");
    send_seq(pat_spread(79));
    take_result("mono79");
  endtask

  task automatic test_backpressure();
    send_seq(pat_half());
    wait_res("bp");
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || res_valid !== 1'b1 || int'($signed(s_sum)) !== sb[0].s ||
          int'(fail_cnt) !== sb[0].fcnt) begin
        errors++;
        $display("FAIL bp_hold: in_ready=%b res_valid=%b s=%0d fc=%0d required 0/1/%0d/%0d",
                 in_ready, res_valid, $signed(s_sum), fail_cnt, sb[0].s, sb[0].fcnt);
      end
    end
    in_valid = 1'b0;
    take_result("bp");
    send_seq(pat_alt());
    take_result("bp_fresh");
  endtask

  task automatic test_abort();
    send_bits('1, 50);
    // clear wins over a bit offered in the same cycle
    @(negedge clk);
    bit_in = 1'b1;
    clear  = 1'b1;
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    send_seq(pat_alt());
    take_result("abort");
    // clear in HOLD drops res_valid but keeps the verdict registers
    send_seq('1);
    wait_res("abort_hold");
    clear     = 1'b1;
    res_ready = 1'b1;
    @(negedge clk);
    clear     = 1'b0;
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1 || int'($signed(s_sum)) !== 128 ||
        int'(fail_cnt) !== exp_fail) begin
      errors++;
      $display("FAIL abort_hold: rv=%b ir=%b s=%0d fc=%0d required 0/1/128/%0d",
               res_valid, in_ready, $signed(s_sum), fail_cnt, exp_fail);
    end
    if (sb.size() != 0) void'(sb.pop_front());
  endtask

  task automatic test_reset_abort();
    send_bits('1, 50);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    exp_fail = 0;
    checks++;
    if (res_valid !== 1'b0 || fail_cnt !== 8'd0 || s_sum !== '0 || mono_pass !== 1'b0) begin
      errors++;
      $display("FAIL rst_abort_async: rv=%b fc=%0d s=%0d mp=%b required 0/0/0/0",
               res_valid, fail_cnt, s_sum, mono_pass);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_seq(pat_alt());
    take_result("rst_abort");
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_alternating();
    test_diverge();
    test_mono_boundary();
    test_backpressure();
    test_abort();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
